// File: rtl/temp_sample_ctrl_pkg.sv
// Shared definitions for the temperature sampling controller.
//   state_e      : FSM state encoding (3-bit)
//   Def*         : default values for the top-level parameters
//   cnt_width()  : counter width needed to reach a given terminal count
package temp_sample_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StWait   = 3'd1,
    StReq    = 3'd2,
    StUpdate = 3'd3,
    StFault  = 3'd4
  } state_e;

  localparam int unsigned DefPeriod   = 50;
  localparam int unsigned DefTimeout  = 8;
  localparam logic [4:0]  DefMaxValid = 5'd30;

  // A terminal count of 0 still needs a 1-bit register.
  function automatic int unsigned cnt_width(input int unsigned terminal);
    return (terminal == 0) ? 1 : $clog2(terminal + 1);
  endfunction

endpackage

// File: rtl/tsc_counter.sv
// Up-counter with synchronous clear/load and a terminal-count flag.
// Ports:
//   clock, reset : clock, asynchronous active-high reset
//   clear        : zero the count (highest priority)
//   load         : load load_val
//   load_val     : value for load
//   inc          : count up by one
//   tc           : count equals Terminal
module tsc_counter #(
  parameter int unsigned Width    = 4,
  parameter int unsigned Terminal = 15
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             inc,
  output logic             tc
);

  logic [Width-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (inc) begin
      count <= count + Width'(1);
    end
  end

  assign tc = (count == Width'(Terminal));

endmodule

// File: rtl/temp_sample_ctrl.sv
// Periodic temperature sampling controller.
// Requests a sample every PERIOD cycles, validates the returned code against
// MAX_VALID, publishes accepted codes with a one-cycle strobe and serves
// coalesced user read requests right after a valid update.
// Ports:
//   clock, reset   : clock, asynchronous active-high reset
//   enable         : run periodic sampling
//   adc_ack        : sensor acknowledge, adc_data valid while high
//   adc_data       : raw 5-bit temperature code
//   lect_req       : one-cycle user read request
//   clr_err        : one-cycle fault clear
//   adc_req        : sample request (registered)
//   temperatura    : last accepted temperature
//   en_m1          : one-cycle strobe, temperatura just updated
//   lect           : one-cycle read strobe
//   range_err      : sticky, out-of-range code rejected
//   timeout_err    : sticky, acknowledge did not arrive in time
//   sample_cnt     : accepted sample count (wraps)
module temp_sample_ctrl
  import temp_sample_ctrl_pkg::*;
#(
  parameter int unsigned PERIOD    = DefPeriod,
  parameter int unsigned TIMEOUT   = DefTimeout,
  parameter logic [4:0]  MAX_VALID = DefMaxValid
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       adc_ack,
  input  logic [4:0] adc_data,
  input  logic       lect_req,
  input  logic       clr_err,
  output logic       adc_req,
  output logic [4:0] temperatura,
  output logic       en_m1,
  output logic       lect,
  output logic       range_err,
  output logic       timeout_err,
  output logic [7:0] sample_cnt
);

  localparam int unsigned PerW = cnt_width(PERIOD - 1);
  localparam int unsigned ToW  = cnt_width(TIMEOUT - 1);

  state_e state;
  logic   pend;
  logic   per_inc, per_clear, per_tc;
  logic   to_inc, to_clear, to_tc;

  // Counters run only in their own state and sit at zero everywhere else,
  // so entering WAIT or REQ always starts from a cleared count.
  assign per_inc   = (state == StWait);
  assign per_clear = !per_inc || per_tc;
  assign to_inc    = (state == StReq);
  assign to_clear  = !to_inc || to_tc;

  tsc_counter #(
    .Width   (PerW),
    .Terminal(PERIOD - 1)
  ) u_period (
    .clock   (clock),
    .reset   (reset),
    .clear   (per_clear),
    .load    (1'b0),
    .load_val('0),
    .inc     (per_inc),
    .tc      (per_tc)
  );

  tsc_counter #(
    .Width   (ToW),
    .Terminal(TIMEOUT - 1)
  ) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .clear   (to_clear),
    .load    (1'b0),
    .load_val('0),
    .inc     (to_inc),
    .tc      (to_tc)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= StIdle;
      adc_req     <= 1'b0;
      temperatura <= '0;
      en_m1       <= 1'b0;
      lect        <= 1'b0;
      range_err   <= 1'b0;
      timeout_err <= 1'b0;
      sample_cnt  <= '0;
      pend        <= 1'b0;
    end else begin
      en_m1 <= 1'b0;
      lect  <= 1'b0;
      if (lect_req) begin
        pend <= 1'b1;
      end
      if (clr_err && (state != StFault)) begin
        range_err <= 1'b0;
      end
      case (state)
        StIdle: begin
          if (enable) begin
            state <= StWait;
          end
        end
        StWait: begin
          if (!enable) begin
            state <= StIdle;
          end else if (per_tc) begin
            state   <= StReq;
            adc_req <= 1'b1;
          end
        end
        StReq: begin
          if (!enable) begin
            state   <= StIdle;
            adc_req <= 1'b0;
          end else if (adc_ack) begin
            // The code is judged on the acknowledge edge so that en_m1 is
            // already high during the UPDATE cycle (one-cycle latency).
            state   <= StUpdate;
            adc_req <= 1'b0;
            if (adc_data <= MAX_VALID) begin
              temperatura <= adc_data;
              en_m1       <= 1'b1;
              sample_cnt  <= sample_cnt + 8'd1;
            end else begin
              range_err <= 1'b1;  // overrides a same-cycle clr_err
            end
          end else if (to_tc) begin
            state       <= StFault;
            adc_req     <= 1'b0;
            timeout_err <= 1'b1;
          end
        end
        StUpdate: begin
          // en_m1 high here means this update was accepted.
          if (en_m1 && pend) begin
            lect <= 1'b1;
            if (!lect_req) begin
              pend <= 1'b0;
            end
          end
          state <= enable ? StWait : StIdle;
        end
        StFault: begin
          if (clr_err) begin
            range_err   <= 1'b0;
            timeout_err <= 1'b0;
            state       <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
